param_negate_serial: RTL and testbench
======================================

// Module: param_negate_serial
// PURPOSE
//  Bit-serial increment stage that consumes the N-bit bitwise-inverted operand produced by the
//  ALU inverter stage. Adds INC (0 or 1) LSB-first, one bit per clock. With INC=1 it yields the
//  two's-complement negation of the original operand; with INC=0 it passes the one's complement.
//  Feeds the ALU subtract/negate path. Uses a single carry flop, trading latency for area.
// PARAMETERS
//  N   4   operand/result width in bits (N >= 2)
// PORTS
//  clk       in   1    rising-edge clock
//  reset     in   1    synchronous, active-high reset
//  start     in   1    begin operation; sampled only in IDLE
//  inc       in   1    carry-in: 1 = two's complement (+1), 0 = one's complement (+0)
//  inv_in    in   N    inverted operand (~a) from the inverter stage
//  busy      out  1    high in RUN and DONE
//  done      out  1    one-cycle pulse; result valid
//  result    out  N    inv_in + inc (mod 2^N); held until the next accepted start
//  cout      out  1    carry out of bit N-1
//  ovf       out  1    signed overflow: inc=1 and inv_in = 0111..1 (a = most-negative value)
// BEHAVIOUR
//  - Reset is synchronous, active-high, on one clock. Next edge: state=IDLE; result=0, cout=0,
//    ovf=0, done=0, busy=0; internal shift reg, carry flop and bit counter cleared.
//  - States: IDLE, RUN, DONE.
//    IDLE: start=1 at edge T0 -> latch inv_in into shift reg, carry<=inc, cnt<=0,
//          latch op_msb=inv_in[N-1]. Go to RUN. start=0 -> stay in IDLE.
//    RUN:  each edge: s = sh[0]^carry; carry <= sh[0]&carry; shift right with s entering
//          at bit N-1; cnt <= cnt+1. At cnt==N-1 -> go to DONE.
//          Bits 0..N-1 are processed at edges T0+1..T0+N.
//    DONE: done=1 for this cycle only. result = assembled word; cout = final carry;
//          ovf = ~op_msb & result[N-1]. Next edge -> IDLE.
//  - Latency: done is high in the cycle after edge T0+N (N+1 edges after the start edge).
//    Back-to-back throughput is one operation per N+2 cycles.
//  - start while busy=1 is ignored; no queueing. inv_in and inc are sampled only at the
//    accepting edge; later changes do not affect the operation in flight.
//  - result, cout and ovf change only on entry to DONE (or on reset). They are stable in IDLE.
//  - Wrap-around: inv_in=1111, inc=1 -> result 0000, cout=1, ovf=0.
//  - reset during RUN or DONE takes priority: abort, return to IDLE with the reset values
//    above, and emit no done pulse.
//  - start and reset in the same cycle: reset wins and start is dropped.
//  - cnt width is clog2(N); arithmetic is unsigned mod 2^N, and ovf reports the signed case.
// TESTING
//  1 N=4, inv_in=1010 (a=5), inc=1, start@T0 -> done in cycle after T0+4, result=1011, cout=0,
//    ovf=0.
//  2 inv_in=0111 (a=-8), inc=1 -> result=1000, ovf=1, cout=0. inv_in=1111, inc=1 ->
//    result=0000, cout=1, ovf=0.
//  3 inv_in=0101, inc=0 -> result=0101, cout=0, ovf=0 (one's-complement pass).
//  4 Hold start=1 for 10 cycles with inv_in=1110, inc=1 -> ops accepted at T0 and T0+6 only,
//    each with result=1111; done pulses exactly one cycle each; busy low only at T0+5.
//  5 Assert reset at T0+2 mid-RUN -> next edge: busy=0, done=0, result=0000; no done pulse
//    follows. A new start then completes normally.
//  6 Change inv_in/inc every cycle during RUN -> result equals the value latched at the start
//    edge. Random sweep over all 16x2 inputs matches (inv_in+inc) mod 16.

Source files
------------

// File: rtl/param_negate_serial.sv
// Bit-serial incrementer: adds inc (0/1) to an N-bit inverted operand, LSB first,
// using a single carry flop. Produces one's or two's complement of the original operand.
module param_negate_serial #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         inc,
   input  logic [N-1:0] inv_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         ovf
);
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [N-1:0]  sh;
   logic [N-1:0]  sh_next;
   logic          carry;
   logic          s;
   logic [CW-1:0] cnt;
   logic          op_msb;

   // One-bit half adder; the sum bit enters at the top so the word ends LSB-aligned.
   always_comb begin
      s       = sh[0] ^ carry;
      sh_next = {s, sh[N-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         sh     <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         op_msb <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sh     <= inv_in;
                  carry  <= inc;
                  cnt    <= '0;
                  op_msb <= inv_in[N-1];
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sh    <= sh_next;
               carry <= sh[0] & carry;
               cnt   <= cnt + CW'(1);
               // Final bit: publish the assembled word directly from the next-state value.
               if (cnt == CW'(N - 1)) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  result <= sh_next;
                  cout   <= sh[0] & carry;
                  ovf    <= ~op_msb & s;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_param_negate_serial.sv
// Scoreboard bench for param_negate_serial: expected results are queued at issue time
// and popped by an independent monitor whenever done is observed.
module tb_param_negate_serial;
   localparam int unsigned N = 4;

   typedef struct packed {
      logic [N-1:0] r;
      logic         c;
      logic         o;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         inc = 1'b0;
   logic [N-1:0] inv_in = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         cout;
   logic         ovf;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic prev_done = 1'b0;

   param_negate_serial #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .inc    (inc),
      .inv_in (inv_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the original operand a = ~inv_in.
   function automatic exp_t model(input logic [N-1:0] v, input logic ci);
      exp_t        e;
      logic [N:0]  sum;
      logic [N-1:0] a;
      logic [N-1:0] most_neg;
      sum      = {1'b0, v} + {{N{1'b0}}, ci};
      a        = ~v;
      most_neg = '0;
      most_neg[N-1] = 1'b1;
      e.r = sum[N-1:0];
      e.c = sum[N];
      e.o = ci && (a == most_neg);
      return e;
   endfunction

   always @(negedge clk) begin
      if (done) begin
         check("done_single_cycle", {31'b0, prev_done}, 32'd0);
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", {{(32-N){1'b0}}, result}, {{(32-N){1'b0}}, e.r});
            check("cout", {31'b0, cout}, {31'b0, e.c});
            check("ovf", {31'b0, ovf}, {31'b0, e.o});
         end
      end
      prev_done = done;
   end

   task automatic wait_idle();
      int unsigned t;
      t = 0;
      @(negedge clk);
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   // Issue one op, then scramble inputs every cycle while it is in flight.
   task automatic do_op(input logic [N-1:0] v, input logic ci);
      wait_idle();
      inv_in = v;
      inc    = ci;
      start  = 1'b1;
      q.push_back(model(v, ci));
      @(negedge clk);
      start = 1'b0;
      repeat (N + 1) begin
         inv_in = N'($urandom);
         inc    = 1'($urandom);
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", {{(32-N){1'b0}}, result}, 32'd0);
      check("rst_cout", {31'b0, cout}, 32'd0);
      check("rst_ovf", {31'b0, ovf}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed cases, including most-negative operand and wrap-around.
      do_op(4'b1010, 1'b1);
      do_op(4'b0111, 1'b1);
      do_op(4'b1111, 1'b1);
      do_op(4'b0101, 1'b0);

      // start held high for 10 cycles: accepted at T0 and T0+6 only.
      wait_idle();
      inv_in = 4'b1110;
      inc    = 1'b1;
      start  = 1'b1;
      q.push_back(model(4'b1110, 1'b1));
      q.push_back(model(4'b1110, 1'b1));
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("held_busy", {31'b0, busy}, (k == 5) ? 32'd0 : 32'd1);
         check("held_done", {31'b0, done}, (k == 4) ? 32'd1 : 32'd0);
      end
      start = 1'b0;

      // Reset mid-RUN aborts with no done pulse.
      wait_idle();
      inv_in = 4'b0011;
      inc    = 1'b1;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_result", {{(32-N){1'b0}}, result}, 32'd0);
      check("abort_cout", {31'b0, cout}, 32'd0);
      check("abort_ovf", {31'b0, ovf}, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check("abort_no_done", {31'b0, done}, 32'd0);
      end
      do_op(4'b1001, 1'b1);

      // Exhaustive sweep of all inputs, then random ops.
      for (int i = 0; i < (2 ** (N + 1)); i++) begin
         do_op(N'(i), 1'((i >> N) & 1));
      end
      for (int i = 0; i < 40; i++) begin
         do_op(N'($urandom), 1'($urandom));
      end

      t = 0;
      while (q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain_queue_empty", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
